// File: rtl/tbird_seq_ctrl.sv
// Thunderbird tail-light sequencer.
// Synchronizes three switch requests, optionally debounces them and steps a
// left/right/hazard lamp FSM on a prescaled tick. Lamp and mode outputs are
// registered alongside the state register, so they add no latency.
// Optional feature: define TBIRD_DEBOUNCE_EN to filter each synchronized switch
// through a DB_CYCLES-sample debouncer; otherwise the synchronizer output is used.
module tbird_seq_ctrl #(
    parameter int unsigned TICK_DIV  = 5,
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SW0,
    input  logic       SW1,
    input  logic       SW2,
    output logic [7:0] TLIGHT,
    output logic [1:0] MODE
);

    localparam logic [3:0] IDLE = 4'd0;
    localparam logic [3:0] L1   = 4'd1;
    localparam logic [3:0] L2   = 4'd2;
    localparam logic [3:0] L3   = 4'd3;
    localparam logic [3:0] R1   = 4'd4;
    localparam logic [3:0] R2   = 4'd5;
    localparam logic [3:0] R3   = 4'd6;
    localparam logic [3:0] HON  = 4'd7;
    localparam logic [3:0] HOFF = 4'd8;

    localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);

    logic [2:0] sync_1;
    logic [2:0] sync_2;
    logic [2:0] filt;
    logic [7:0] pre_cnt;
    logic       tick;
    logic       haz;
    logic [3:0] state;
    logic [3:0] state_d;
    logic [7:0] tlight_d;
    logic [1:0] mode_d;

    // Two-flop synchronizer for the asynchronous switch levels.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_1 <= 3'b000;
            sync_2 <= 3'b000;
        end else begin
            sync_1 <= {SW2, SW1, SW0};
            sync_2 <= sync_1;
        end
    end

`ifdef TBIRD_DEBOUNCE_EN
    localparam logic [3:0] DB_LAST = 4'(DB_CYCLES - 1);

    logic [3:0] db_cnt [3];

    // Per-switch debouncer: count samples that disagree with the filtered value,
    // adopt the new value after DB_CYCLES in a row; agreement restarts the count.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            filt <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync_2[i] == filt[i]) begin
                    db_cnt[i] <= 4'd0;
                end else if (db_cnt[i] == DB_LAST) begin
                    filt[i]   <= sync_2[i];
                    db_cnt[i] <= 4'd0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 4'd1;
                end
            end
        end
    end
`else
    assign filt = sync_2;
`endif

    assign tick = (pre_cnt == TICK_LAST);
    // Both switches together count as a hazard request.
    assign haz  = filt[2] | (filt[0] & filt[1]);

    // Free-running prescaler, wraps at TICK_DIV-1.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pre_cnt <= 8'd0;
        end else if (tick) begin
            pre_cnt <= 8'd0;
        end else begin
            pre_cnt <= pre_cnt + 8'd1;
        end
    end

    // Next-state logic; state only advances on tick.
    always_comb begin
        state_d = state;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (haz)          state_d = HON;
                    else if (filt[0]) state_d = L1;
                    else if (filt[1]) state_d = R1;
                    else              state_d = IDLE;
                end
                L1:      state_d = haz ? HON : L2;
                L2:      state_d = haz ? HON : L3;
                L3:      state_d = haz ? HON : IDLE;
                R1:      state_d = haz ? HON : R2;
                R2:      state_d = haz ? HON : R3;
                R3:      state_d = haz ? HON : IDLE;
                HON:     state_d = haz ? HOFF : IDLE;
                HOFF:    state_d = haz ? HON : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output decode from next state so outputs register with the state.
    always_comb begin
        tlight_d = 8'h00;
        mode_d   = 2'b00;
        case (state_d)
            L1:   begin tlight_d = 8'h48; mode_d = 2'b01; end
            L2:   begin tlight_d = 8'h58; mode_d = 2'b01; end
            L3:   begin tlight_d = 8'h78; mode_d = 2'b01; end
            R1:   begin tlight_d = 8'h41; mode_d = 2'b10; end
            R2:   begin tlight_d = 8'h43; mode_d = 2'b10; end
            R3:   begin tlight_d = 8'h47; mode_d = 2'b10; end
            HON:  begin tlight_d = 8'hFF; mode_d = 2'b11; end
            HOFF: begin tlight_d = 8'hC0; mode_d = 2'b11; end
            default: begin tlight_d = 8'h00; mode_d = 2'b00; end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            TLIGHT <= 8'h00;
            MODE   <= 2'b00;
        end else begin
            state  <= state_d;
            TLIGHT <= tlight_d;
            MODE   <= mode_d;
        end
    end

endmodule
